// File: rtl/mem_port_arbiter_pkg.sv
// Shared defaults and small types for the two-requester memory port arbiter.
// Imported by the interface, the round-robin sub-module and the top level.
package mem_arb_pkg;

    localparam int AW_DEF = 4;
    localparam int DW_DEF = 32;
    localparam int NREQ   = 2;

    // Index of a requester; with two requesters a single bit suffices.
    typedef logic req_idx_t;

    function automatic int nb_of(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side command/response bundle of the memory port arbiter.
// master = client logic, slave = arbiter.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    localparam int NB = nb_of(DW);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*NB-1:0] req_be;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_data;

    modport master (
        output req_valid, req_we, req_addr, req_be, req_wdata,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_be, req_wdata,
        output req_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: priority starts at ptr_reg, and after a grant
// the pointer moves to the requester that did not win.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    req_idx_t ptr_reg;
    req_idx_t ptr_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_reg <= 1'b0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (|gnt) begin
            ptr_next = ~gnt[1];
        end
    end

    always_comb begin
        gnt = 2'b00;
        if (ptr_reg == 1'b0) begin
            gnt[0] = req[0];
            gnt[1] = req[1] & ~req[0];
        end else begin
            gnt[1] = req[1];
            gnt[0] = req[0] & ~req[1];
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one byte-enabled write port and one registered read port between two
// requesters; same-cycle same-address read/write is resolved write-first.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int AW = AW_DEF,
    parameter  int DW = DW_DEF,
    localparam int NB = nb_of(DW)
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_port_arbiter_if.slave    bus,
    output logic [AW-1:0]        mem_rd_addr,
    input  logic [DW-1:0]        mem_rd_data,
    output logic [AW-1:0]        mem_wr_addr,
    output logic [NB-1:0]        mem_wr_en,
    output logic [DW-1:0]        mem_wr_data
);

    logic [NREQ-1:0] rd_cand;
    logic [NREQ-1:0] wr_cand;
    logic [NREQ-1:0] rd_gnt;
    logic [NREQ-1:0] wr_gnt;
    req_idx_t        rd_idx;
    req_idx_t        wr_idx;
    logic            collide;

    logic [AW-1:0] addr_arr  [NREQ];
    logic [NB-1:0] be_arr    [NREQ];
    logic [DW-1:0] wdata_arr [NREQ];

    logic [NREQ-1:0] rsp_valid_reg;
    logic            byp_hit_reg;
    logic [NB-1:0]   byp_be_reg;
    logic [DW-1:0]   byp_data_reg;
    logic [DW-1:0]   merged_data;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign addr_arr[gi]  = bus.req_addr[gi*AW +: AW];
            assign be_arr[gi]    = bus.req_be[gi*NB +: NB];
            assign wdata_arr[gi] = bus.req_wdata[gi*DW +: DW];
        end
    endgenerate

    assign rd_cand = bus.req_valid & ~bus.req_we;
    assign wr_cand = bus.req_valid &  bus.req_we;

    rr_arb2 u_rd_arb (
        .clk   (clk),
        .reset (reset),
        .req   (rd_cand),
        .gnt   (rd_gnt)
    );

    rr_arb2 u_wr_arb (
        .clk   (clk),
        .reset (reset),
        .req   (wr_cand),
        .gnt   (wr_gnt)
    );

    // Grants are one-hot, so bit 1 alone names the winner.
    assign rd_idx        = rd_gnt[1];
    assign wr_idx        = wr_gnt[1];
    assign bus.req_ready = rd_gnt | wr_gnt;

    assign mem_rd_addr = addr_arr[rd_idx];
    assign mem_wr_addr = addr_arr[wr_idx];
    assign mem_wr_data = wdata_arr[wr_idx];
    assign mem_wr_en   = (|wr_gnt) ? be_arr[wr_idx] : '0;

    assign collide = (|rd_gnt) && (|wr_gnt) && (addr_arr[rd_idx] == addr_arr[wr_idx]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_reg <= '0;
            byp_hit_reg   <= 1'b0;
            byp_be_reg    <= '0;
            byp_data_reg  <= '0;
        end else begin
            rsp_valid_reg <= rd_gnt;
            byp_hit_reg   <= collide;
            byp_be_reg    <= mem_wr_en;
            byp_data_reg  <= mem_wr_data;
        end
    end

    // The memory returns pre-write data on a same-cycle collision, so the
    // written lanes are patched in from the bypass registers.
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign merged_data[gi*8 +: 8] = (byp_hit_reg && byp_be_reg[gi])
                                          ? byp_data_reg[gi*8 +: 8]
                                          : mem_rd_data[gi*8 +: 8];
        end
    endgenerate

    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_data  = (|rsp_valid_reg) ? merged_data : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural registered-read
// memory attached to the memory-side ports.
module tb_mem_port_arbiter;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int NB = DW / 8;

    logic          clk;
    logic          reset;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic [AW-1:0] mem_wr_addr;
    logic [NB-1:0] mem_wr_en;
    logic [DW-1:0] mem_wr_data;

    logic [DW-1:0] mem_model [1 << AW];

    int checks;
    int errors;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(input int i);
        logic [7:0] b;
        b = 8'(i);
        case (i)
            5:       return 32'h11223344;
            7:       return 32'h77777777;
            default: return {4{b}};
        endcase
    endfunction

    // Read-first memory: a same-edge write is not visible to the read.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < (1 << AW); i++) mem_model[i] <= init_word(i);
            mem_rd_data <= '0;
        end else begin
            mem_rd_data <= mem_model[mem_rd_addr];
            for (int b = 0; b < NB; b++) begin
                if (mem_wr_en[b]) mem_model[mem_wr_addr][b*8 +: 8] <= mem_wr_data[b*8 +: 8];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic idle();
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_be    = '0;
        bus.req_wdata = '0;
    endtask

    task automatic drive(input int r, input logic we, input logic [AW-1:0] addr,
                         input logic [NB-1:0] be, input logic [DW-1:0] data);
        bus.req_valid[r]          = 1'b1;
        bus.req_we[r]             = we;
        bus.req_addr[r*AW +: AW]  = addr;
        bus.req_be[r*NB +: NB]    = be;
        bus.req_wdata[r*DW +: DW] = data;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [1:0]    exp_rdy;
    logic [1:0]    prev_rdy;
    logic [DW-1:0] exp_data;

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'(2'b00));
        check_eq("rst_rsp_data",  64'(bus.rsp_data),  64'(0));
        check_eq("rst_wr_en",     64'(mem_wr_en),      64'(0));
        check_eq("rst_ready",     64'(bus.req_ready),  64'(2'b00));
        next_cycle();
        reset = 1'b0;

        // Write addr 3, then read it back from the other requester.
        drive(0, 1'b1, 4'd3, 4'hF, 32'hDEADBEEF);
        @(negedge clk);
        check_eq("wr3_ready",   64'(bus.req_ready), 64'(2'b01));
        check_eq("wr3_wr_en",   64'(mem_wr_en),     64'(4'hF));
        check_eq("wr3_wr_addr", 64'(mem_wr_addr),   64'(3));
        next_cycle();
        idle();
        drive(1, 1'b0, 4'd3, 4'h0, 32'h0);
        @(negedge clk);
        check_eq("rd3_ready",   64'(bus.req_ready), 64'(2'b10));
        check_eq("rd3_rd_addr", 64'(mem_rd_addr),   64'(3));
        next_cycle();
        idle();
        @(negedge clk);
        check_eq("rd3_rsp_valid", 64'(bus.rsp_valid), 64'(2'b10));
        check_eq("rd3_rsp_data",  64'(bus.rsp_data),  64'(32'hDEADBEEF));

        // Both requesters read continuously: grants alternate 0,1,0,1.
        next_cycle();
        drive(0, 1'b0, 4'd1, 4'h0, 32'h0);
        drive(1, 1'b0, 4'd2, 4'h0, 32'h0);
        prev_rdy = 2'b00;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k < 4) begin
                exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
                check_eq($sformatf("alt_ready_%0d", k), 64'(bus.req_ready), 64'(exp_rdy));
            end
            if (k > 0) begin
                exp_data = (prev_rdy == 2'b01) ? 32'h01010101 : 32'h02020202;
                check_eq($sformatf("alt_rsp_valid_%0d", k), 64'(bus.rsp_valid), 64'(prev_rdy));
                check_eq($sformatf("alt_rsp_data_%0d", k),  64'(bus.rsp_data),  64'(exp_data));
            end
            if (k < 4) prev_rdy = exp_rdy;
            next_cycle();
            if (k == 3) idle();
        end

        // Same-cycle collision on addr 5: write-first byte merge.
        drive(0, 1'b1, 4'd5, 4'b0101, 32'hAABBCCDD);
        drive(1, 1'b0, 4'd5, 4'h0, 32'h0);
        @(negedge clk);
        check_eq("col_ready", 64'(bus.req_ready), 64'(2'b11));
        next_cycle();
        idle();
        @(negedge clk);
        check_eq("col_rsp_valid", 64'(bus.rsp_valid), 64'(2'b10));
        check_eq("col_rsp_data",  64'(bus.rsp_data),  64'(32'h11BB33DD));

        // Zero byte-enable write is accepted but leaves memory untouched.
        next_cycle();
        drive(1, 1'b1, 4'd7, 4'h0, 32'hFFFFFFFF);
        @(negedge clk);
        check_eq("be0_ready", 64'(bus.req_ready), 64'(2'b10));
        check_eq("be0_wr_en", 64'(mem_wr_en),     64'(0));
        next_cycle();
        idle();
        drive(0, 1'b0, 4'd7, 4'h0, 32'h0);
        @(negedge clk);
        check_eq("rd7_ready", 64'(bus.req_ready), 64'(2'b01));
        next_cycle();
        idle();
        @(negedge clk);
        check_eq("rd7_rsp_valid", 64'(bus.rsp_valid), 64'(2'b01));
        check_eq("rd7_rsp_data",  64'(bus.rsp_data),  64'(32'h77777777));

        // Reset right after a read grant drops the response and clears ptr.
        next_cycle();
        drive(0, 1'b0, 4'd1, 4'h0, 32'h0);
        @(negedge clk);
        check_eq("rr_ready", 64'(bus.req_ready), 64'(2'b01));
        #1;
        reset = 1'b1;
        idle();
        @(negedge clk);
        check_eq("rr_rsp_valid_a", 64'(bus.rsp_valid), 64'(2'b00));
        @(negedge clk);
        check_eq("rr_rsp_valid_b", 64'(bus.rsp_valid), 64'(2'b00));
        check_eq("rr_rsp_data",    64'(bus.rsp_data),  64'(0));
        next_cycle();
        reset = 1'b0;
        drive(0, 1'b0, 4'd1, 4'h0, 32'h0);
        drive(1, 1'b0, 4'd2, 4'h0, 32'h0);
        @(negedge clk);
        check_eq("tie_ready", 64'(bus.req_ready), 64'(2'b01));
        next_cycle();
        idle();
        @(negedge clk);
        check_eq("tie_rsp_valid", 64'(bus.rsp_valid), 64'(2'b01));
        check_eq("tie_rsp_data",  64'(bus.rsp_data),  64'(32'h01010101));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
